// File: rtl/dil_pkg.sv
// Shared Dilithium arithmetic constants and coefficient/product types.
package dil_pkg;

   localparam int unsigned COEF_W = 23;
   localparam int unsigned PROD_W = 46;
   localparam logic [COEF_W-1:0] Q = 23'd8380417;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/red_d.sv
// Combinational reduction of a 46-bit product modulo Q = 2^23 - 2^13 + 1.
module red_d
   import dil_pkg::*;
(
   input  prod_t x,
   output coef_t r
);

   localparam int unsigned SH   = 13;
   localparam int unsigned T1_W = 37;
   localparam int unsigned T2_W = 28;
   localparam int unsigned T3_W = 24;

   logic [T1_W-1:0] t1;
   logic [T2_W-1:0] t2;
   logic [T3_W-1:0] t3;

   // 2^23 == 2^13 - 1 (mod Q): fold the high part three times, then one conditional subtract
   always_comb begin
      t1 = T1_W'({x[PROD_W-1:COEF_W], SH'(0)}) - T1_W'(x[PROD_W-1:COEF_W])
         + T1_W'(x[COEF_W-1:0]);
      t2 = T2_W'({t1[T1_W-1:COEF_W], SH'(0)}) - T2_W'(t1[T1_W-1:COEF_W])
         + T2_W'(t1[COEF_W-1:0]);
      t3 = T3_W'({t2[T2_W-1:COEF_W], SH'(0)}) - T3_W'(t2[T2_W-1:COEF_W])
         + T3_W'(t2[COEF_W-1:0]);
      r  = (t3 >= T3_W'(Q)) ? COEF_W'(t3 - T3_W'(Q)) : COEF_W'(t3);
   end

endmodule

// File: rtl/mulred_arb_d.sv
// Round-robin shared modular multiplier: N_REQ requesters -> 3-stage (a*b) mod Q pipeline.
// Optional MULRED_ARB_PERF_EN adds result-handshake and stall-cycle counters.
module mulred_arb_d
   import dil_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  coef_t [N_REQ-1:0]     req_a_i,
   input  coef_t [N_REQ-1:0]     req_b_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [ID_W-1:0]       res_id_o,
   output coef_t                 res_data_o,
   output logic                  busy_o
`ifdef MULRED_ARB_PERF_EN
   ,
   output logic [31:0]           perf_ops_o,
   output logic [31:0]           perf_stall_o
`endif
);

   logic            stall_s;
   logic            hs;
   logic            grant_v;
   logic [ID_W-1:0] grant;
   logic [ID_W-1:0] ptr_q;

   logic            s1_v;
   coef_t           s1_a;
   coef_t           s1_b;
   logic [ID_W-1:0] s1_id;
   logic            s2_v;
   prod_t           s2_prod;
   logic [ID_W-1:0] s2_id;
   coef_t           red_r;

   assign stall_s = res_valid_o & ~res_ready_i;
   assign hs      = |(req_valid_i & req_ready_o);
   assign busy_o  = s1_v | s2_v | res_valid_o;

   // Lowest valid index above ptr wins; otherwise wrap to the lowest valid index
   always_comb begin
      grant_v = 1'b0;
      grant   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grant_v = 1'b1;
            grant   = ID_W'(i);
         end
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i] && (ID_W'(i) > ptr_q)) begin
            grant = ID_W'(i);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      if (!rst_i && !stall_s && grant_v) begin
         req_ready_o[grant] = 1'b1;
      end
   end

   red_d u_red (
      .x (s2_prod),
      .r (red_r)
   );

   // Pointer and pipeline; every stage advances together unless the output stalls
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q       <= ID_W'(N_REQ - 1);
         s1_v        <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_id       <= '0;
         s2_v        <= 1'b0;
         s2_prod     <= '0;
         s2_id       <= '0;
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         res_id_o    <= '0;
      end else begin
         if (hs) begin
            ptr_q <= grant;
         end
         if (!stall_s) begin
            s1_v        <= hs;
            s1_a        <= req_a_i[grant];
            s1_b        <= req_b_i[grant];
            s1_id       <= grant;
            s2_v        <= s1_v;
            s2_prod     <= PROD_W'(s1_a) * PROD_W'(s1_b);
            s2_id       <= s1_id;
            res_valid_o <= s2_v;
            res_data_o  <= red_r;
            res_id_o    <= s2_id;
         end
      end
   end

`ifdef MULRED_ARB_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_ops_o   <= '0;
         perf_stall_o <= '0;
      end else begin
         if (res_valid_o && res_ready_i) begin
            perf_ops_o <= perf_ops_o + 32'd1;
         end
         if (stall_s) begin
            perf_stall_o <= perf_stall_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mulred_arb_d.sv
// Self-checking bench for mulred_arb_d: directed vector table, corner sequences, randomized traffic vs. a reference model.
module tb_mulred_arb_d;
   import dil_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned IW = 2;
   localparam longint unsigned QL = 64'd8380417;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   coef_t [N-1:0] req_a;
   coef_t [N-1:0] req_b;
   logic          res_valid;
   logic          res_ready;
   logic [IW-1:0] res_id;
   coef_t         res_data;
   logic          busy;
`ifdef MULRED_ARB_PERF_EN
   logic [31:0]   perf_ops;
   logic [31:0]   perf_stall;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mulred_arb_d #(.N_REQ(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_id_o    (res_id),
      .res_data_o  (res_data),
      .busy_o      (busy)
`ifdef MULRED_ARB_PERF_EN
      ,
      .perf_ops_o  (perf_ops),
      .perf_stall_o(perf_stall)
`endif
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a 3-slot occupancy list, round-robin from the last winner, results computed as (a*b)%Q
   typedef struct { bit v; int unsigned id; longint unsigned data; } ent_t;
   typedef struct { int unsigned id; longint unsigned data; } res_t;

   ent_t        mp [3];
   int unsigned mptr;
   logic [31:0] m_ops;
   logic [31:0] m_stall;
   res_t        rlog [$];
   bit          m_stall_now;
   bit          m_gv;
   int unsigned m_g;
   int unsigned m_idx;
   logic [N-1:0] m_er;

   always @(negedge clk) begin
      if (rst) begin
         check("ready_in_reset", 64'(req_ready), 64'd0);
         for (int s = 0; s < 3; s++) mp[s] = '{v: 1'b0, id: 0, data: 0};
         mptr    = N - 1;
         m_ops   = '0;
         m_stall = '0;
      end else begin
         m_stall_now = mp[2].v && !res_ready;
         m_gv = 1'b0;
         m_g  = 0;
         if (!m_stall_now) begin
            for (int k = 1; k <= int'(N); k++) begin
               m_idx = (mptr + k) % N;
               if (!m_gv && 1'(req_valid >> m_idx)) begin
                  m_gv = 1'b1;
                  m_g  = m_idx;
               end
            end
         end
         m_er = m_gv ? N'(1) << m_g : '0;
         check("req_ready", 64'(req_ready), 64'(m_er));
         check("res_valid", 64'(res_valid), 64'(mp[2].v));
         if (mp[2].v) begin
            check("res_id", 64'(res_id), 64'(mp[2].id));
            check("res_data", 64'(res_data), mp[2].data);
         end
         check("busy", 64'(busy), 64'(mp[0].v | mp[1].v | mp[2].v));
`ifdef MULRED_ARB_PERF_EN
         check("perf_ops", 64'(perf_ops), 64'(m_ops));
         check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif
         if (res_valid && res_ready) rlog.push_back('{id: 32'(res_id), data: 64'(res_data)});
         if (mp[2].v && res_ready) m_ops = m_ops + 32'd1;
         if (m_stall_now) m_stall = m_stall + 32'd1;
         if (!m_stall_now) begin
            mp[2]    = mp[1];
            mp[1]    = mp[0];
            mp[0].v  = m_gv;
            mp[0].id = m_g;
            mp[0].data = m_gv ? ((64'(req_a[IW'(m_g)]) * 64'(req_b[IW'(m_g)])) % QL) : 64'd0;
            if (m_gv) mptr = m_g;
         end
      end
   end

   task automatic present(input logic [IW-1:0] id, input coef_t a, input coef_t b);
      req_valid[id] = 1'b1;
      req_a[id]     = a;
      req_b[id]     = b;
   endtask

   task automatic wait_accept(input logic [IW-1:0] id);
      bit got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         got = req_ready[id];
         @(posedge clk); #1;
      end
      req_valid[id] = 1'b0;
      check("accept", 64'(got), 64'd1);
   endtask

   task automatic issue(input logic [IW-1:0] id, input coef_t a, input coef_t b);
      present(id, a, b);
      wait_accept(id);
   endtask

   typedef struct { logic [IW-1:0] id; coef_t a; coef_t b; coef_t exp; } vec_t;

   // Single op with idle pipeline: latency 3, expected product from the table
   task automatic do_op(input vec_t v);
      int    lat = 0;
      coef_t d   = '0;
      logic [IW-1:0] rid = '0;
      issue(v.id, v.a, v.b);
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(negedge clk);
         if (res_valid) begin
            lat = n;
            d   = res_data;
            rid = res_id;
         end
         @(posedge clk); #1;
      end
      check("op_latency", 64'(lat), 64'd3);
      check("op_data", 64'(d), 64'(v.exp));
      check("op_id", 64'(rid), 64'(v.id));
   endtask

   task automatic random_phase(input int cycles);
      bit acc [N];
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         for (int i = 0; i < int'(N); i++) acc[i] = req_valid[IW'(i)] & req_ready[IW'(i)];
         @(posedge clk); #1;
         res_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < int'(N); i++) begin
            if (!req_valid[IW'(i)] || acc[i]) begin
               if ($urandom_range(1) == 1) begin
                  req_valid[IW'(i)] = 1'b1;
                  case ($urandom_range(3))
                     0:       req_a[IW'(i)] = 23'd8380416;
                     1:       req_a[IW'(i)] = 23'd0;
                     default: req_a[IW'(i)] = 23'($urandom_range(8380416));
                  endcase
                  req_b[IW'(i)] = 23'($urandom_range(8380416));
               end else begin
                  req_valid[IW'(i)] = 1'b0;
               end
            end
         end
      end
      req_valid = '0;
      res_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   vec_t vt [7];
   int   gseq [6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{id: 2'd0, a: 23'd2,       b: 23'd3,       exp: 23'd6};
      vt[1] = '{id: 2'd1, a: 23'd8380416, b: 23'd8380416, exp: 23'd1};
      vt[2] = '{id: 2'd0, a: 23'd8380416, b: 23'd2,       exp: 23'd8380415};
      vt[3] = '{id: 2'd2, a: 23'd4096,    b: 23'd4096,    exp: 23'd16382};
      vt[4] = '{id: 2'd1, a: 23'd0,       b: 23'd8380416, exp: 23'd0};
      vt[5] = '{id: 2'd2, a: 23'd1,       b: 23'd8380416, exp: 23'd8380416};
      vt[6] = '{id: 2'd1, a: 23'd8380416, b: 23'd3,       exp: 23'd8380414};
      gseq  = '{0, 1, 0, 1, 0, 1};

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_id", 64'(res_id), 64'd0);
      check("rst_res_data", 64'(res_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) do_op(vt[i]);

      // Two requesters contending: strict alternation, results in grant order
      rlog.delete();
      present(2'd0, 23'd5, 23'd7);
      present(2'd1, 23'd8380416, 23'd8380416);
      for (int h = 0; h < 6; h++) begin
         @(negedge clk);
         check("rr_grant", 64'(req_ready), 64'(N'(1) << gseq[h]));
         @(posedge clk); #1;
      end
      req_valid = '0;
      repeat (5) @(posedge clk);
      #1;
      check("rr_count", 64'(rlog.size()), 64'd6);
      for (int h = 0; h < 6 && h < rlog.size(); h++) begin
         check("rr_res_id", 64'(rlog[h].id), 64'(gseq[h]));
         check("rr_res_data", rlog[h].data, (gseq[h] == 0) ? 64'd35 : 64'd1);
      end

      // Full pipeline held by downstream back-pressure, then drained
      rlog.delete();
      res_ready = 1'b0;
      issue(2'd0, 23'd10, 23'd10);
      issue(2'd0, 23'd11, 23'd10);
      issue(2'd0, 23'd12, 23'd10);
      present(2'd1, 23'd13, 23'd10);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("stall_valid", 64'(res_valid), 64'd1);
         check("stall_data", 64'(res_data), 64'd100);
         check("stall_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      wait_accept(2'd1);
      repeat (6) @(posedge clk);
      #1;
      check("drain_count", 64'(rlog.size()), 64'd4);
      for (int h = 0; h < 4 && h < rlog.size(); h++) begin
         check("drain_data", rlog[h].data, 64'(100 + 10 * h));
         check("drain_id", 64'(rlog[h].id), (h == 3) ? 64'd1 : 64'd0);
      end

      // Reset with three ops in flight
      rlog.delete();
      res_ready = 1'b0;
      issue(2'd1, 23'd20, 23'd2);
      issue(2'd1, 23'd21, 23'd2);
      issue(2'd1, 23'd22, 23'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      check("midrst_res_valid", 64'(res_valid), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_res_data", 64'(res_data), 64'd0);
      @(posedge clk); #1;
      present(2'd0, 23'd8380416, 23'd2);
      present(2'd1, 23'd3, 23'd4);
      @(negedge clk);
      check("post_rst_grant", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_accept(2'd1);
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_count", 64'(rlog.size()), 64'd2);
      if (rlog.size() >= 2) begin
         check("post_rst_d0", rlog[0].data, 64'd8380415);
         check("post_rst_i0", 64'(rlog[0].id), 64'd0);
         check("post_rst_d1", rlog[1].data, 64'd12);
         check("post_rst_i1", 64'(rlog[1].id), 64'd1);
      end
`ifdef MULRED_ARB_PERF_EN
      check("perf_ops_after_rst", 64'(perf_ops), 64'd2);
`endif

      random_phase(3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
